// File: rtl/moving_ground_scroll_ctrl_if.sv
// Bundle between game logic and the ground scroll sequencer: event inputs
// and the per-frame segment coordinates.
interface moving_ground_scroll_ctrl_if;
    logic               startOfFrame;
    logic               enable;
    logic               pauseReq;
    logic               speedUp;
    logic               speedDown;
    logic               collision;
    logic signed [10:0] topLeftX1;
    logic signed [10:0] topLeftX2;
    logic        [10:0] topLeftY;
    logic        [3:0]  speed;
    logic               scrolling;
    logic               crashing;

    modport master (
        output startOfFrame, enable, pauseReq, speedUp, speedDown, collision,
        input  topLeftX1, topLeftX2, topLeftY, speed, scrolling, crashing
    );

    modport slave (
        input  startOfFrame, enable, pauseReq, speedUp, speedDown, collision,
        output topLeftX1, topLeftX2, topLeftY, speed, scrolling, crashing
    );
endinterface

// File: rtl/moving_ground_scroll_ctrl.sv
// Per-frame scroll sequencer for two tiled ground segments: phase counter,
// speed control and a run/pause/crash FSM with registered coordinate outputs.
module moving_ground_scroll_ctrl #(
    parameter int TILE_W       = 640,
    parameter int GROUND_Y     = 440,
    parameter int START_SPEED  = 2,
    parameter int MAX_SPEED    = 8,
    parameter int CRASH_FRAMES = 60
) (
    input  logic                         clk,
    input  logic                         resetN,
    moving_ground_scroll_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, CRASH} state_e;

    localparam logic [10:0] TILE_W_C   = 11'(TILE_W);
    localparam logic [10:0] GROUND_Y_C = 11'(GROUND_Y);
    localparam logic [3:0]  START_C    = 4'(START_SPEED);
    localparam logic [3:0]  MAX_C      = 4'(MAX_SPEED);
    localparam logic [7:0]  CRASH_C    = 8'(CRASH_FRAMES);

    state_e             state_q, state_d;
    logic [9:0]         p_q, p_d;
    logic [3:0]         speed_q, speed_d;
    logic [7:0]         crash_cnt_q, crash_cnt_d;
    logic signed [10:0] x1_q, x2_q;
    logic               scrolling_q, crashing_q;

    logic [10:0] p_sum;
    logic [10:0] p_wrap;
    logic [9:0]  p_adv;
    logic [3:0]  speed_step;

    // speed < TILE_W, so a single subtraction always brings the sum back in range
    assign p_sum  = {1'b0, p_q} + {7'b0, speed_q};
    assign p_wrap = (p_sum >= TILE_W_C) ? (p_sum - TILE_W_C) : p_sum;
    assign p_adv  = p_wrap[9:0];

    always_comb begin
        speed_step = speed_q;
        if (bus.speedUp && !bus.speedDown && speed_q < MAX_C)
            speed_step = speed_q + 4'd1;
        else if (bus.speedDown && !bus.speedUp && speed_q > 4'd1)
            speed_step = speed_q - 4'd1;
    end

    always_comb begin
        // NOTE: every next-state value defaults to its hold value first so no path infers a latch.
        state_d     = state_q;
        p_d         = p_q;
        speed_d     = speed_q;
        crash_cnt_d = crash_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.enable) state_d = RUN;
            end
            RUN: begin
                speed_d = speed_step;
                if (bus.collision) begin
                    state_d     = CRASH;
                    crash_cnt_d = CRASH_C;
                end else begin
                    if (bus.startOfFrame) p_d = p_adv;
                    if (!bus.enable)      state_d = IDLE;
                    else if (bus.pauseReq) state_d = PAUSED;
                end
            end
            PAUSED: begin
                speed_d = speed_step;
                if (bus.collision) begin
                    state_d     = CRASH;
                    crash_cnt_d = CRASH_C;
                end else if (!bus.enable) begin
                    state_d = IDLE;
                end else if (bus.pauseReq) begin
                    state_d = RUN;
                end
            end
            CRASH: begin
                // enable, pause and speed requests are ignored so the crash always completes
                if (bus.startOfFrame) begin
                    if (crash_cnt_q <= 8'd1) begin
                        state_d     = IDLE;
                        p_d         = '0;
                        speed_d     = START_C;
                        crash_cnt_d = '0;
                    end else begin
                        crash_cnt_d = crash_cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            p_q         <= '0;
            speed_q     <= START_C;
            crash_cnt_q <= '0;
            x1_q        <= '0;
            x2_q        <= TILE_W_C;
            scrolling_q <= 1'b0;
            crashing_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q     <= state_d;
            p_q         <= p_d;
            speed_q     <= speed_d;
            crash_cnt_q <= crash_cnt_d;
            // coordinates are built from the next phase so they land with it
            x1_q        <= 11'd0 - {1'b0, p_d};
            x2_q        <= TILE_W_C - {1'b0, p_d};
            scrolling_q <= (state_d == RUN);
            crashing_q  <= (state_d == CRASH);
        end
    end

    assign bus.topLeftX1 = x1_q;
    assign bus.topLeftX2 = x2_q;
    assign bus.topLeftY  = GROUND_Y_C;
    assign bus.speed     = speed_q;
    assign bus.scrolling = scrolling_q;
    assign bus.crashing  = crashing_q;

endmodule

// File: tb/tb_moving_ground_scroll_ctrl.sv
// Bench for the ground scroll sequencer: vector tables and directed sequences
// feeding an expected-output queue that is drained after each clock edge.
`timescale 1ns/1ps
module tb_moving_ground_scroll_ctrl;

    localparam int TILE_W   = 640;
    localparam int GROUND_Y = 440;

    logic clk    = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    moving_ground_scroll_ctrl_if bus ();

    moving_ground_scroll_ctrl #(
        .TILE_W      (TILE_W),
        .GROUND_Y    (GROUND_Y),
        .START_SPEED (2),
        .MAX_SPEED   (8),
        .CRASH_FRAMES(3)
    ) u_dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus)
    );

    typedef struct packed {
        logic sof, en, pz, up, dn, col;
    } in_t;

    typedef struct packed {
        logic signed [10:0] x1;
        logic signed [10:0] x2;
        logic        [10:0] y;
        logic        [3:0]  spd;
        logic               scr;
        logic               crs;
    } out_t;

    typedef struct packed {
        in_t  in;
        out_t exp;
    } vec_t;

    out_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    vec_t t_run[12];
    vec_t t_crash[10];

    function automatic in_t vin(logic sof, logic en, logic pz, logic up, logic dn, logic col);
        return '{sof: sof, en: en, pz: pz, up: up, dn: dn, col: col};
    endfunction

    // Expected outputs from phase p: X1 = -p, X2 = TILE_W - p, Y constant
    function automatic out_t mk(int p, int spd, logic scr, logic crs);
        out_t o;
        o.x1  = 11'(-p);
        o.x2  = 11'(TILE_W - p);
        o.y   = 11'(GROUND_Y);
        o.spd = 4'(spd);
        o.scr = scr;
        o.crs = crs;
        return o;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.x1  = bus.topLeftX1;
        o.x2  = bus.topLeftX2;
        o.y   = bus.topLeftY;
        o.spd = bus.speed;
        o.scr = bus.scrolling;
        o.crs = bus.crashing;
        return o;
    endfunction

    task automatic check(string name, out_t act, out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got x1=%0d x2=%0d y=%0d speed=%0d scrolling=%0b crashing=%0b, expected x1=%0d x2=%0d y=%0d speed=%0d scrolling=%0b crashing=%0b",
                     name, $signed(act.x1), $signed(act.x2), act.y, act.spd, act.scr, act.crs,
                     $signed(exp.x1), $signed(exp.x2), exp.y, exp.spd, exp.scr, exp.crs);
        end
    endtask

    task automatic drive(in_t in);
        bus.startOfFrame = in.sof;
        bus.enable       = in.en;
        bus.pauseReq     = in.pz;
        bus.speedUp      = in.up;
        bus.speedDown    = in.dn;
        bus.collision    = in.col;
    endtask

    // One clock: drive on the falling edge, queue the expectation, compare 1ns after the rising edge
    task automatic step(string name, in_t in, out_t exp);
        out_t e;
        @(negedge clk);
        drive(in);
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            check(name, sample(), e);
        end
    endtask

    initial begin
        int p;
        int spd;

        // sof en pz up dn col -> expected (p, speed, scrolling, crashing)
        t_run[0]  = '{vin(0,1,0,0,0,0), mk(0, 2, 1, 0)};
        t_run[1]  = '{vin(1,1,0,0,0,0), mk(2, 2, 1, 0)};
        t_run[2]  = '{vin(0,1,0,0,0,0), mk(2, 2, 1, 0)};
        t_run[3]  = '{vin(1,1,0,0,0,0), mk(4, 2, 1, 0)};
        t_run[4]  = '{vin(1,1,0,0,0,0), mk(6, 2, 1, 0)};
        t_run[5]  = '{vin(0,1,0,1,1,0), mk(6, 2, 1, 0)};
        t_run[6]  = '{vin(1,1,0,1,0,0), mk(8, 3, 1, 0)};
        t_run[7]  = '{vin(0,1,0,0,1,0), mk(8, 2, 1, 0)};
        t_run[8]  = '{vin(0,0,0,0,0,0), mk(8, 2, 0, 0)};
        t_run[9]  = '{vin(0,0,1,0,0,0), mk(8, 2, 0, 0)};
        t_run[10] = '{vin(0,0,0,1,0,0), mk(8, 2, 0, 0)};
        t_run[11] = '{vin(0,1,0,0,0,0), mk(8, 2, 1, 0)};

        // crash sequence starting from RUN, p=6, speed=2
        t_crash[0] = '{vin(0,1,0,1,0,0), mk(6, 3, 1, 0)};
        t_crash[1] = '{vin(1,1,0,0,0,1), mk(6, 3, 0, 1)};
        t_crash[2] = '{vin(0,1,1,0,0,0), mk(6, 3, 0, 1)};
        t_crash[3] = '{vin(0,0,0,0,0,0), mk(6, 3, 0, 1)};
        t_crash[4] = '{vin(0,0,0,1,0,0), mk(6, 3, 0, 1)};
        t_crash[5] = '{vin(1,0,0,0,0,0), mk(6, 3, 0, 1)};
        t_crash[6] = '{vin(1,0,0,0,0,0), mk(6, 3, 0, 1)};
        t_crash[7] = '{vin(0,0,0,0,0,0), mk(6, 3, 0, 1)};
        t_crash[8] = '{vin(1,0,0,0,0,0), mk(0, 2, 0, 0)};
        t_crash[9] = '{vin(0,0,0,0,0,0), mk(0, 2, 0, 0)};

        drive(vin(0,0,0,0,0,0));
        repeat (3) @(posedge clk);
        #1;
        check("reset_held", sample(), mk(0, 2, 0, 0));
        @(negedge clk);
        resetN = 1'b1;
        #1;
        check("reset_release", sample(), mk(0, 2, 0, 0));

        for (int i = 0; i < 12; i++)
            step($sformatf("run_vec%0d", i), t_run[i].in, t_run[i].exp);

        // Advance at speed 2 up to p=636, raise speed to 8, then wrap
        p = 8;
        for (int i = 0; i < 314; i++) begin
            p = (p + 2) % TILE_W;
            step($sformatf("frame%0d", i), vin(1,1,0,0,0,0), mk(p, 2, 1, 0));
        end
        spd = 2;
        for (int i = 0; i < 6; i++) begin
            spd++;
            step($sformatf("speed_to_max%0d", i), vin(0,1,0,1,0,0), mk(636, spd, 1, 0));
        end
        p = (636 + 8) % TILE_W;
        step("wrap_frame", vin(1,1,0,0,0,0), mk(p, 8, 1, 0));

        // Saturation at both ends
        for (int i = 0; i < 20; i++) begin
            spd = (spd < 8) ? spd + 1 : 8;
            step($sformatf("sat_up%0d", i), vin(0,1,0,1,0,0), mk(4, spd, 1, 0));
        end
        for (int i = 0; i < 20; i++) begin
            spd = (spd > 1) ? spd - 1 : 1;
            step($sformatf("sat_dn%0d", i), vin(0,1,0,0,1,0), mk(4, spd, 1, 0));
        end
        step("up_dn_same_cycle", vin(0,1,0,1,1,0), mk(4, 1, 1, 0));
        step("restore_speed", vin(0,1,0,1,0,0), mk(4, 2, 1, 0));

        // Pause freezes the ground for 5 frames, second pause resumes
        step("pause_enter", vin(0,1,1,0,0,0), mk(4, 2, 0, 0));
        for (int i = 0; i < 5; i++)
            step($sformatf("paused_frame%0d", i), vin(1,1,0,0,0,0), mk(4, 2, 0, 0));
        step("pause_exit", vin(0,1,1,0,0,0), mk(4, 2, 1, 0));
        step("resume_frame", vin(1,1,0,0,0,0), mk(6, 2, 1, 0));

        for (int i = 0; i < 10; i++)
            step($sformatf("crash_vec%0d", i), t_crash[i].in, t_crash[i].exp);

        // Asynchronous reset in the middle of a crash at p=100
        step("rerun", vin(0,1,0,0,0,0), mk(0, 2, 1, 0));
        for (int i = 0; i < 50; i++)
            step($sformatf("to100_frame%0d", i), vin(1,1,0,0,0,0), mk(2 * (i + 1), 2, 1, 0));
        step("crash_at_100", vin(0,1,0,0,0,1), mk(100, 2, 0, 1));
        step("crash_frame", vin(1,1,0,0,0,0), mk(100, 2, 0, 1));
        @(negedge clk);
        drive(vin(0,0,0,0,0,0));
        #2;
        resetN = 1'b0;
        #1;
        check("async_reset_mid_crash", sample(), mk(0, 2, 0, 0));
        @(negedge clk);
        resetN = 1'b1;
        step("idle_after_reset", vin(0,0,0,0,0,0), mk(0, 2, 0, 0));
        step("run_after_reset", vin(0,1,0,0,0,0), mk(0, 2, 1, 0));
        step("frame_after_reset", vin(1,1,0,0,0,0), mk(2, 2, 1, 0));

        drive(vin(0,0,0,0,0,0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/moving_ground_scroll_ctrl.md
# moving_ground_scroll_ctrl

Per-frame scroll sequencer for the two horizontally tiled ground segments of the playfield. It owns a phase counter and produces the top-left coordinates for ground segment 1 and ground segment 2, whose square-object drawers feed the ground draw-request/offset mux. Game logic drives it with enable, pause, speed and collision events. An internal FSM runs, pauses, freezes on crash and recovers.

## Interface
Parameters:
- TILE_W, 640, width of each ground segment in pixels (legal 2..1023).
- GROUND_Y, 440, constant top-left Y of both segments.
- START_SPEED, 2, speed after reset and after crash recovery (1..MAX_SPEED).
- MAX_SPEED, 8, speed saturation limit (≤15, < TILE_W).
- CRASH_FRAMES, 60, frames held in CRASH before returning to IDLE (1..255).

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- startOfFrame  in  1  single-cycle pulse, once per frame.
- enable  in  1  level; game running.
- pauseReq  in  1  single-cycle pulse; toggles RUN/PAUSED.
- speedUp  in  1  single-cycle pulse; speed +1.
- speedDown  in  1  single-cycle pulse; speed −1.
- collision  in  1  single-cycle pulse; player hit.
- topLeftX1  out  11 signed  segment 1 X.
- topLeftX2  out  11 signed  segment 2 X.
- topLeftY  out  11  both segments' Y.
- speed  out  4  current speed, in pixels per frame.
- scrolling  out  1  1 only in RUN.
- crashing  out  1  1 only in CRASH.

## Operation
- Phase register p: unsigned 10 bits, range 0..TILE_W−1.
- Outputs: topLeftX1 = −p and topLeftX2 = TILE_W − p, both 11-bit two's complement. topLeftY = GROUND_Y.
- RUN advance: on startOfFrame, p ← p + speed. If the sum is ≥ TILE_W, subtract TILE_W once. No other wrap case exists because speed < TILE_W.
- FSM states: IDLE, RUN, PAUSED, CRASH.
  - IDLE → RUN when enable = 1.
  - RUN → PAUSED on pauseReq.
  - PAUSED → RUN on pauseReq.
  - RUN or PAUSED → CRASH on collision. The crash counter loads CRASH_FRAMES.
  - CRASH: the counter decrements on each startOfFrame. When it reaches 0, go to IDLE, set p ← 0 and speed ← START_SPEED.
  - In RUN or PAUSED, enable = 0 → IDLE; p and speed are held.
  - In CRASH, enable is ignored, so the crash always completes.
- p changes only in RUN. IDLE, PAUSED and CRASH freeze the ground.
- Speed updates are accepted only in RUN and PAUSED. Speed saturates at 1 and at MAX_SPEED. If speedUp and speedDown arrive in the same cycle, speed does not change.
- Simultaneous events:
  - collision has priority over pauseReq and over enable = 0.
  - collision together with startOfFrame in RUN: no advance.
  - A speed change in the same cycle as startOfFrame: the advance uses the old speed.
  - pauseReq in IDLE or CRASH is ignored.
- Reset values:
  - p = 0, so topLeftX1 = 0 and topLeftX2 = TILE_W.
  - topLeftY = GROUND_Y.
  - speed = START_SPEED.
  - state IDLE, scrolling = 0, crashing = 0, crash counter = 0.

## Timing
- All outputs are registered.
- topLeftX1/X2 reflect the new p one clk after the startOfFrame edge that advanced it. They are stable for the rest of the frame.
- State transitions take effect one clk after the triggering input. scrolling and crashing follow in the same cycle as the state register.
- Speed change is visible on speed one clk after the pulse.
- CRASH exit happens on the clk after the CRASH_FRAMES-th startOfFrame following entry.
- Asserting resetN low at any time forces all reset values immediately, including mid-crash and mid-advance.

## Test plan
- Reset, enable = 1, 3 frames at speed 2: X1 goes 0 → −2 → −4 → −6, X2 = 640 − p each frame, scrolling = 1 from the cycle after enable.
- Wrap: set p to 636 with speed 8 (drive speedUp ×6), then one frame: p = 4, X1 = −4, X2 = 636. X2 is never < 0 and X1 is never ≤ −640.
- speedUp ×20 then speedDown ×20, one pulse per cycle: speed saturates at 8, then at 1. speedUp and speedDown together: speed is unchanged.
- Pause: pauseReq in RUN, then 5 frames: X unchanged and scrolling = 0. A second pauseReq resumes and advances on the next frame.
- Crash, with CRASH_FRAMES = 3: collision and startOfFrame together in RUN give no advance and crashing = 1. pauseReq and enable = 0 during CRASH are ignored. After 3 frames: IDLE, X1 = 0, X2 = 640, speed = 2.
- Assert resetN low mid-CRASH at p = 100: all outputs return to reset values asynchronously, and the state is IDLE after release.
